// File: rtl/ss_scan_ctrl.sv
// rtl/ss_scan_ctrl.sv - multiplexed seven-segment scan controller with tear-free frame buffer
// Define SS_SCAN_LZB_EN to enable leading-zero blanking.
module ss_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 1000,
  parameter int GAP        = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    upd_valid,
  input  logic [4*NUM_DIGITS-1:0] upd_data,
  output logic                    upd_ready,
  output logic [3:0]              dec_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int W    = 4 * NUM_DIGITS;
  localparam int MAXC = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(NUM_DIGITS);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [W-1:0]          r_pend;
  logic                  r_pend_full;
  logic [W-1:0]          r_active;
  logic [NUM_DIGITS-1:0] r_an;
  logic [3:0]            r_dec;
  logic                  r_ready;
  logic                  r_fd;

  logic       w_xfer;
  logic [3:0] w_code;
  logic       w_lit;
  logic       w_last_dwell;
  logic       w_last_gap;
  logic       w_wrap;

  assign w_xfer       = upd_valid && r_ready;
  assign w_code       = r_active[{r_idx, 2'b00} +: 4];
  assign w_last_dwell = (r_cnt == CW'(DWELL - 1));
  assign w_last_gap   = (r_cnt == CW'(GAP - 1));
  assign w_wrap       = (r_idx == IW'(NUM_DIGITS - 1));

`ifdef SS_SCAN_LZB_EN
  logic [W-1:0] w_upper;
  // Digit k is blank when it and every more-significant digit are zero; digit 0 always lights.
  assign w_upper = r_active >> {r_idx, 2'b00};
  assign w_lit   = (r_idx == '0) || (w_upper != '0);
`else
  assign w_lit = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_active    <= '0;
      r_an        <= '0;
      r_dec       <= '0;
      r_ready     <= 1'b1;
      r_fd        <= 1'b0;
    end else begin
      // ready stays low the cycle of a copy-out, so a transfer never collides with it
      r_ready <= w_xfer ? 1'b0 : !r_pend_full;
      if (w_xfer) begin
        r_pend      <= upd_data;
        r_pend_full <= 1'b1;
      end
      r_an <= (r_state == S_DRIVE && w_lit) ? (NUM_DIGITS'(1) << r_idx) : '0;
      if (r_state == S_DRIVE) r_dec <= w_code;
      r_fd <= (r_state == S_DRIVE) && w_last_dwell && w_wrap;

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_idx <= '0;
          if (en) begin
            r_state <= S_DRIVE;
            if (r_pend_full) begin
              r_active    <= r_pend;
              r_pend_full <= 1'b0;
            end
          end
        end
        S_DRIVE: begin
          if (w_last_dwell) begin
            r_state <= S_GAP;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (w_last_gap) begin
            r_cnt <= '0;
            if (!en) begin
              r_state <= S_IDLE;
              r_idx   <= '0;
            end else begin
              r_state <= S_DRIVE;
              if (w_wrap) begin
                r_idx <= '0;
                if (r_pend_full) begin
                  r_active    <= r_pend;
                  r_pend_full <= 1'b0;
                end
              end else begin
                r_idx <= r_idx + IW'(1);
              end
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_idx   <= '0;
        end
      endcase
    end
  end

  assign upd_ready  = r_ready;
  assign dec_in     = r_dec;
  assign an         = r_an;
  assign frame_done = r_fd;

endmodule

// File: tb/tb_ss_scan_ctrl.sv
// tb/tb_ss_scan_ctrl.sv - self-checking bench for ss_scan_ctrl (4 digits, dwell 4, gap 2)
module tb_ss_scan_ctrl;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int G  = 2;
  localparam int DP = D + G;
  localparam int FP = N * DP;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          upd_valid;
  logic [4*N-1:0] upd_data;
  logic          upd_ready;
  logic [3:0]    dec_in;
  logic [N-1:0]  an;
  logic          frame_done;

  ss_scan_ctrl #(.NUM_DIGITS(N), .DWELL(D), .GAP(G)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .upd_valid(upd_valid), .upd_data(upd_data),
    .upd_ready(upd_ready), .dec_in(dec_in), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h at %0t", nm, act, req, $time);
  endtask

  // Model: m_ph is the position within the frame; outputs trail it by one cycle.
  bit            m_run, m_ready, m_pfull, pf_old, xfer, start, lit;
  int            m_ph, d;
  logic [15:0]   m_act, m_pend;
  logic [N-1:0]  exp_an;
  logic [3:0]    exp_dec;
  bit            exp_fd, exp_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_ph = 0; m_act = '0; m_pend = '0; m_pfull = 0; m_ready = 1;
      exp_an = '0; exp_dec = '0; exp_fd = 0; exp_ready = 1;
    end else begin
      d   = m_ph / DP;
      lit = m_run && (m_ph % DP < D);
      if (lit) exp_dec = m_act[4*d +: 4];
`ifdef SS_SCAN_LZB_EN
      lit = lit && (d == 0 || (m_act >> (4 * d)) != 0);
`endif
      exp_an = lit ? N'(1 << d) : '0;
      exp_fd = m_run && (m_ph == FP - G - 1);

      pf_old  = m_pfull;
      xfer    = upd_valid && m_ready;
      m_ready = !xfer && !pf_old;
      if (xfer) begin m_pend = upd_data; m_pfull = 1; end

      start = 0;
      if (!m_run) begin
        if (en) begin m_run = 1; m_ph = 0; start = 1; end
      end else begin
        m_ph++;
        if (m_ph % DP == 0) begin
          if (!en) begin m_run = 0; m_ph = 0; end
          else if (m_ph == FP) begin m_ph = 0; start = 1; end
        end
      end
      if (start && pf_old) begin m_act = m_pend; m_pfull = 0; end
      exp_ready = m_ready;
    end
  end

  bit chk_on = 0;
  always @(negedge clk) begin
    if (chk_on && rst_n) begin
      check("an", an, exp_an);
      check("dec_in", dec_in, exp_dec);
      check("frame_done", frame_done, exp_fd);
      check("upd_ready", upd_ready, exp_ready);
    end
  end

  task automatic wait_an(input logic [N-1:0] v);
    int k = 0;
    while (an !== v && k < 200) begin @(negedge clk); k++; end
    check("wait_an", an, v);
  endtask

  logic [N-1:0] s_an  [FP];
  logic [3:0]   s_dec [FP];
  logic         s_fd  [FP];

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, fd_cnt;
    rst_n = 0; en = 0; upd_valid = 0; upd_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    check("rst_an", an, 0);
    check("rst_dec", dec_in, 0);
    check("rst_ready", upd_ready, 1);
    check("rst_fd", frame_done, 0);
    chk_on = 1;
    repeat (50) @(negedge clk);

    upd_data = 16'h4321; upd_valid = 1;
    @(negedge clk); upd_valid = 0;
    check("ready_drop", upd_ready, 0);
    en = 1;
    @(negedge clk);
    check("en_lag_an", an, 0);
    check("ready_before_copy", upd_ready, 0);
    @(negedge clk);
    check("ready_after_copy", upd_ready, 1);
    for (int i = 0; i < FP; i++) begin
      s_an[i] = an; s_dec[i] = dec_in; s_fd[i] = frame_done;
      @(negedge clk);
    end
    check("seq_an0", s_an[0], 4'b0001);
    check("seq_an3", s_an[3], 4'b0001);
    check("seq_an4", s_an[4], 4'b0000);
    check("seq_an6", s_an[6], 4'b0010);
    check("seq_an12", s_an[12], 4'b0100);
    check("seq_an18", s_an[18], 4'b1000);
    check("seq_an22", s_an[22], 4'b0000);
    check("seq_dec0", s_dec[0], 1);
    check("seq_dec5_hold", s_dec[5], 1);
    check("seq_dec6", s_dec[6], 2);
    check("seq_dec12", s_dec[12], 3);
    check("seq_dec18", s_dec[18], 4);
    check("seq_fd21", s_fd[21], 1);
    fd_cnt = 0;
    for (int i = 0; i < FP; i++) fd_cnt += int'(s_fd[i]);
    check("fd_per_frame", fd_cnt, 1);

    wait_an(4'b0100);
    upd_data = 16'h9876; upd_valid = 1;
    @(negedge clk); upd_valid = 0;
    check("upd2_ready_drop", upd_ready, 0);
    check("upd2_old_d2", dec_in, 3);
    wait_an(4'b1000);
    check("upd2_old_d3", dec_in, 4);
    wait_an(4'b0001);
    check("upd2_new_d0", dec_in, 6);
    check("upd2_ready_rise", upd_ready, 1);
    wait_an(4'b0010);
    check("upd2_new_d1", dec_in, 7);

    upd_data = 16'h5555; upd_valid = 1;
    @(negedge clk);
    upd_data = 16'h2468;
    k = 0;
    while (!upd_ready && k < 100) begin @(negedge clk); k++; end
    check("stall_bound", upd_ready, 1);
    @(negedge clk); upd_valid = 0;
    check("frameA_d0", dec_in, 5);
    wait_an(4'b1000);
    check("frameA_d3", dec_in, 5);
    wait_an(4'b0001);
    check("frameB_d0", dec_in, 8);

    wait_an(4'b0010);
    en = 0;
    repeat (20) @(negedge clk);
    check("idle_after_drop", an, 0);
    en = 1;
    @(negedge clk); @(negedge clk);
    check("restart_d0", an, 4'b0001);
    check("restart_dec", dec_in, 8);

    upd_data = 16'h1357; upd_valid = 1;
    @(negedge clk); upd_valid = 0;
    check("pre_rst_ready", upd_ready, 0);
    wait_an(4'b0010);
    #2 rst_n = 0;
    #1;
    check("async_an", an, 0);
    check("async_ready", upd_ready, 1);
    check("async_dec", dec_in, 0);
    @(negedge clk); rst_n = 1;
    repeat (30) @(negedge clk);

`ifdef SS_SCAN_LZB_EN
    upd_data = 16'h0005; upd_valid = 1;
    @(negedge clk); upd_valid = 0;
    wait_an(4'b0001);
    wait_an(4'b0001);
    check("lzb_d0", dec_in, 5);
    repeat (FP) @(negedge clk);
`endif

    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
